// File: rtl/fadd32_pkg.sv
// Shared FP32 constants, adder mode encodings and accumulator state type.
package fadd32_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7fc0_0000;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

endpackage

// File: rtl/fadd32_acc_if.sv
// Sample-in / sum-out handshake bundle of the FP32 frame accumulator.
interface fadd32_acc_if #(
  parameter int unsigned CNT_W = 16
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output clear, in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  clear, in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/fadd32.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even,
// gradual underflow; NaN operands are returned unchanged.
module fadd32
  import fadd32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mode_i,
  output logic [31:0] sum_c_o
);

  logic [31:0] b_eff;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic [7:0]  ea, eb, el, es, d, sh;
  logic [23:0] ma, mb, ml, ms;
  logic        sl, ss;
  logic [26:0] ext, lost, ms_sh, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [8:0]  exp_n;
  logic        up;
  logic [24:0] rnd;

  // Align, add, normalise, round, then let specials override.
  always_comb begin
    b_eff = {b_i[31] ^ (mode_i == MODE_SUB), b_i[30:0]};
    a_nan = (&a_i[30:23]) && (|a_i[22:0]);
    b_nan = (&b_i[30:23]) && (|b_i[22:0]);
    a_inf = (&a_i[30:23]) && !(|a_i[22:0]);
    b_inf = (&b_i[30:23]) && !(|b_i[22:0]);
    // Subnormals use exponent 1 with no hidden bit
    ea = (a_i[30:23] == 8'd0) ? 8'd1 : a_i[30:23];
    eb = (b_i[30:23] == 8'd0) ? 8'd1 : b_i[30:23];
    ma = {|a_i[30:23], a_i[22:0]};
    mb = {|b_i[30:23], b_i[22:0]};
    swap = {ea, ma} < {eb, mb};
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;
    sl = swap ? b_eff[31] : a_i[31];
    ss = swap ? a_i[31] : b_eff[31];
    d  = el - es;

    // Shift the smaller operand right, folding lost bits into a sticky bit
    ext   = {ms, 3'b000};
    lost  = '0;
    if (d >= 8'd27) begin
      ms_sh = {26'd0, |ms};
    end else begin
      ms_sh = ext >> d;
      lost  = ext & ((27'd1 << d) - 27'd1);
      ms_sh[0] = ms_sh[0] | (|lost);
    end

    if (sl == ss) sum = {1'b0, ml, 3'b000} + {1'b0, ms_sh};
    else          sum = {1'b0, ml, 3'b000} - {1'b0, ms_sh};

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    // Left shift is capped so the exponent never drops below the subnormal floor
    sh = '0;
    if (sum[27]) begin
      norm  = sum[27:1] | {26'd0, sum[0]};
      exp_n = 9'(el) + 9'd1;
    end else begin
      sh    = ({3'b000, lz} > (el - 8'd1)) ? (el - 8'd1) : {3'b000, lz};
      norm  = sum[26:0] << sh;
      exp_n = 9'(el) - 9'(sh);
    end

    up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + 25'(up);
    if (rnd[24]) begin
      rnd   = rnd >> 1;
      exp_n = exp_n + 9'd1;
    end

    if (exp_n >= 9'd255)      sum_c_o = {sl, 8'hff, 23'd0};
    else if (!rnd[23])        sum_c_o = {sl & (rnd != 25'd0 || sl == ss), 8'd0, rnd[22:0]};
    else                      sum_c_o = {sl, exp_n[7:0], rnd[22:0]};

    if (a_nan)                          sum_c_o = a_i;
    else if (b_nan)                     sum_c_o = b_i;
    else if (a_inf && b_inf && (a_i[31] != b_eff[31])) sum_c_o = FP_QNAN;
    else if (a_inf)                     sum_c_o = a_i;
    else if (b_inf)                     sum_c_o = b_eff;
  end

endmodule

// File: rtl/fadd32_acc.sv
// Streaming FP32 frame accumulator: one sample per clock into a running sum,
// result held behind a valid/ready handshake until consumed.
module fadd32_acc
  import fadd32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fadd32_acc_if.slave   bus
);

  acc_state_t       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic [31:0]      fadd_sum_c;
  logic             in_ready_c;
  logic             accept_c;

  fadd32 u_fadd32 (
    .a_i     (acc_q),
    .b_i     (bus.in_data),
    .mode_i  (bus.in_sub),
    .sum_c_o (fadd_sum_c)
  );

  // run_q gives a clean synchronous release: no sample is taken during reset
  assign in_ready_c    = run_q && (state_q == ACC) && !bus.clear;
  assign accept_c      = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;

  // Next-state: clear dominates, then accept in ACC or handshake in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = ACC;
      acc_d   = FP_POS_ZERO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept_c) begin
            acc_d = fadd_sum_c;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            if (bus.in_last) state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = ACC;
            acc_d   = FP_POS_ZERO;
            cnt_d   = '0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State, accumulator and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= FP_POS_ZERO;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fadd32_acc.sv
// Directed bench for fadd32_acc with a frame-result scoreboard.
module tb_fadd32_acc;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fadd32_acc_if #(.CNT_W(CNT_W)) bus ();

  fadd32_acc #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score any output handshake about to happen, then land at posedge+1.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.clear === 1'b0) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed sum %h with empty scoreboard", bus.out_sum);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_sum", bus.out_sum, e.sum);
        chk("sb_count", 32'(bus.out_count), e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic sub, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sub   = sub;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_sub   = 1'b0;
  endtask

  task automatic expect_frame(input logic [31:0] sum, input logic [31:0] cnt);
    exp_t e;
    e.sum = sum;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    bus.clear = 1'b0;  bus.in_valid = 1'b0; bus.in_data = '0;
    bus.in_sub = 1'b0; bus.in_last = 1'b0;  bus.out_ready = 1'b1;

    // Reset values
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_sum", bus.out_sum, 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // 1.0 + 2.0 + 3.0
    expect_frame(32'h40c0_0000, 3);
    send(32'h3f80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    send(32'h4040_0000, 1'b0, 1'b1);
    chk("t1_valid_lat1", 32'(bus.out_valid), 32'd1);
    chk("t1_sum_direct", bus.out_sum, 32'h40c0_0000);
    tick();
    chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);

    // 4.0 - 0.5
    expect_frame(32'h4060_0000, 2);
    send(32'h4080_0000, 1'b0, 1'b0);
    send(32'h3f00_0000, 1'b1, 1'b1);
    tick();

    // Backpressure with the next frame waiting
    bus.out_ready = 1'b0;
    expect_frame(32'h4000_0000, 1);
    send(32'h4000_0000, 1'b0, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 32'h3f80_0000; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_ready_low", 32'(bus.in_ready), 32'd0);
      chk("t3_hold_sum", bus.out_sum, 32'h4000_0000);
      tick();
    end
    expect_frame(32'h3f80_0000, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_after_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_after_hs_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("t3_next_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // Clear mid-frame drops the offered sample
    send(32'h3f80_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b0, 1'b0);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h4040_0000;
    #1;
    chk("t4_ready_clear", 32'(bus.in_ready), 32'd0);
    tick();
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    chk("t4_acc_zero", bus.out_sum, 32'h0);
    chk("t4_cnt_zero", 32'(bus.out_count), 32'd0);
    expect_frame(32'h4080_0000, 1);
    send(32'h4080_0000, 1'b0, 1'b1);
    tick();

    // Async reset while holding a result
    bus.out_ready = 1'b0;
    send(32'h3f80_0000, 1'b0, 1'b1);
    chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_sum", bus.out_sum, 32'h0);
    chk("t5_rst_count", 32'(bus.out_count), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("t5_release_ready", 32'(bus.in_ready), 32'd1);
    expect_frame(32'h3f80_0000, 1);
    send(32'h3f80_0000, 1'b0, 1'b1);
    tick();

    // Back-to-back frames, valid and ready held high
    expect_frame(32'h4000_0000, 2);
    expect_frame(32'h4120_0000, 1);
    bus.in_valid = 1'b1; bus.in_data = 32'h3f80_0000; bus.in_last = 1'b0;
    tick();
    bus.in_last = 1'b1;
    tick();
    bus.in_data = 32'h4120_0000;
    #1;
    chk("t6_done_no_accept", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tick();

    // Signed zero, NaN pass-through, Inf-Inf, cancellation, RNE tie, subnormals
    expect_frame(32'h0000_0000, 1);
    send(32'h8000_0000, 1'b0, 1'b1);
    tick();
    expect_frame(32'h7fc0_0001, 2);
    send(32'h3f80_0000, 1'b0, 1'b0);
    send(32'h7fc0_0001, 1'b1, 1'b1);
    tick();
    expect_frame(32'h7fc0_0000, 2);
    send(32'h7f80_0000, 1'b0, 1'b0);
    send(32'h7f80_0000, 1'b1, 1'b1);
    tick();
    expect_frame(32'h0000_0000, 2);
    send(32'h3fc0_0000, 1'b0, 1'b0);
    send(32'h3fc0_0000, 1'b1, 1'b1);
    tick();
    expect_frame(32'h3f80_0002, 2);
    send(32'h3f80_0000, 1'b0, 1'b0);
    send(32'h3440_0000, 1'b0, 1'b1);
    tick();
    expect_frame(32'h0000_0002, 2);
    send(32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0001, 1'b0, 1'b1);
    tick();

    // Counter saturates while the sum keeps growing
    expect_frame(32'h4188_0000, 32'(2**CNT_W - 1));
    for (int i = 0; i < 16; i++) send(32'h3f80_0000, 1'b0, 1'b0);
    send(32'h3f80_0000, 1'b0, 1'b1);
    tick();

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
